// File: rtl/rr_arbiter.sv
// Round-robin arbiter with packet lock; registered one-hot grant drives a
// downstream one-hot mux select directly.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  req_last,
  input  logic          ready,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id,
  output logic          valid
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  grant_reg, grant_next;
  logic [IW-1:0] id_reg, id_next;
  logic [IW-1:0] ptr_reg, ptr_next;

  logic          release_now;
  logic [IW-1:0] search_base;
  logic [N-1:0]  search_mask;
  logic [N-1:0]  rot;
  logic [IW-1:0] rot_idx [N];
  logic          win_found;
  logic [IW-1:0] win_id;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      id_reg    <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      id_reg    <= id_next;
      ptr_reg   <= ptr_next;
    end
  end

  // A dropped request while granted is handled exactly like an accepted last beat.
  always_comb begin
    release_now = 1'b0;
    search_base = ptr_reg;
    search_mask = req;
    if (state_reg == BUSY) begin
      release_now = (ready && req_last[id_reg]) || !req[id_reg];
      search_base = (id_reg == IW'(N - 1)) ? '0 : id_reg + IW'(1);
      search_mask = req & ~grant_reg;
    end
  end

  // Rotate the candidate requests so position 0 is the highest-priority index.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IW:0] sum;
    assign sum         = {1'b0, search_base} + (IW + 1)'(gi);
    assign rot_idx[gi] = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : IW'(sum);
    assign rot[gi]     = search_mask[rot_idx[gi]];
  end

  always_comb begin
    win_found = |rot;
    win_id    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) win_id = rot_idx[k];
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    id_next    = id_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next         = BUSY;
          grant_next         = '0;
          grant_next[win_id] = 1'b1;
          id_next            = win_id;
        end
      end
      BUSY: begin
        if (release_now) begin
          ptr_next = search_base;
          if (win_found) begin
            grant_next         = '0;
            grant_next[win_id] = 1'b1;
            id_next            = win_id;
          end else begin
            state_next = IDLE;
            grant_next = '0;
            id_next    = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant    = grant_reg;
    grant_id = id_reg;
    valid    = (state_reg == BUSY);
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: N=2, 4 and 5 instances checked every cycle against a
// queue-free round-robin reference model; directed spec scenarios plus random traffic.
module tb_rr_arbiter;

  localparam int NS [3] = '{2, 4, 5};

  logic       clk = 1'b0;
  logic       nreset;
  logic [4:0] req_v  [3];
  logic [4:0] last_v [3];
  logic       ready_v[3];

  logic [1:0] g2;  logic [0:0] id2; logic v2;
  logic [3:0] g4;  logic [1:0] id4; logic v4;
  logic [4:0] g5;  logic [2:0] id5; logic v5;

  logic [4:0] obs_g  [3];
  logic [2:0] obs_id [3];
  logic       obs_v  [3];

  int n_assert = 0;
  int n_fail   = 0;
  int n_step   = 0;
  bit chk_on   = 1'b0;

  int m_busy [3];
  int m_gid  [3];
  int m_ptr  [3];

  always #5 clk = ~clk;

  rr_arbiter #(.N(2)) u2 (.clk(clk), .nreset(nreset), .req(req_v[0][1:0]), .req_last(last_v[0][1:0]),
                          .ready(ready_v[0]), .grant(g2), .grant_id(id2), .valid(v2));
  rr_arbiter #(.N(4)) u4 (.clk(clk), .nreset(nreset), .req(req_v[1][3:0]), .req_last(last_v[1][3:0]),
                          .ready(ready_v[1]), .grant(g4), .grant_id(id4), .valid(v4));
  rr_arbiter #(.N(5)) u5 (.clk(clk), .nreset(nreset), .req(req_v[2]), .req_last(last_v[2]),
                          .ready(ready_v[2]), .grant(g5), .grant_id(id5), .valid(v5));

  assign obs_g[0]  = 5'(g2);  assign obs_id[0] = 3'(id2); assign obs_v[0] = v2;
  assign obs_g[1]  = 5'(g4);  assign obs_id[1] = 3'(id4); assign obs_v[1] = v4;
  assign obs_g[2]  = g5;      assign obs_id[2] = id5;     assign obs_v[2] = v5;

  // Structural invariant: one-hot-or-zero and consistent with grant_id/valid.
  a_inv2: assert property (@(posedge clk) disable iff (!chk_on)
            $onehot0(g2) && (g2 == (v2 ? (2'd1 << id2) : 2'd0)))
            n_assert++;
          else begin
            n_fail++;
            $error("FAIL inv_n2: grant=%b id=%0d valid=%b", $sampled(g2), $sampled(id2), $sampled(v2));
          end
  a_inv4: assert property (@(posedge clk) disable iff (!chk_on)
            $onehot0(g4) && (g4 == (v4 ? (4'd1 << id4) : 4'd0)))
            n_assert++;
          else begin
            n_fail++;
            $error("FAIL inv_n4: grant=%b id=%0d valid=%b", $sampled(g4), $sampled(id4), $sampled(v4));
          end
  a_inv5: assert property (@(posedge clk) disable iff (!chk_on)
            $onehot0(g5) && (g5 == (v5 ? (5'd1 << id5) : 5'd0)))
            n_assert++;
          else begin
            n_fail++;
            $error("FAIL inv_n5: grant=%b id=%0d valid=%b", $sampled(g5), $sampled(id5), $sampled(v5));
          end

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // First requester found walking ptr, ptr+1, ... modulo n.
  function automatic int pick(input int n, input int p, input logic [4:0] r);
    for (int k = 0; k < n; k++) begin
      if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic model_edge(input int d);
    int n;
    int w;
    logic [4:0] others;
    n = NS[d];
    if (!nreset) begin
      m_busy[d] = 0; m_gid[d] = 0; m_ptr[d] = 0;
    end else if (m_busy[d] == 0) begin
      w = pick(n, m_ptr[d], req_v[d]);
      if (w >= 0) begin m_busy[d] = 1; m_gid[d] = w; end
    end else if ((ready_v[d] && last_v[d][m_gid[d]]) || !req_v[d][m_gid[d]]) begin
      if (!req_v[d][m_gid[d]])
        $display("note: n%0d requester %0d dropped req while granted", n, m_gid[d]);
      m_ptr[d] = (m_gid[d] + 1) % n;
      others = req_v[d] & ~(5'd1 << m_gid[d]);
      w = pick(n, m_ptr[d], others);
      if (w >= 0) m_gid[d] = w;
      else begin m_busy[d] = 0; m_gid[d] = 0; end
    end
  endtask

  task automatic step();
    for (int d = 0; d < 3; d++) model_edge(d);
    @(posedge clk);
    #1;
    n_step++;
    $display("step %0d rst_n=%b n4: req=%b last=%b rdy=%b -> grant=%b id=%0d valid=%b",
             n_step, nreset, req_v[1][3:0], last_v[1][3:0], ready_v[1], g4, id4, v4);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("n%0d_grant", NS[d]), obs_g[d], (m_busy[d] != 0) ? (5'd1 << m_gid[d]) : 5'd0);
      chk($sformatf("n%0d_grant_id", NS[d]), 5'(obs_id[d]), 5'(m_gid[d]));
      chk($sformatf("n%0d_valid", NS[d]), 5'(obs_v[d]), 5'(m_busy[d] != 0));
    end
  endtask

  task automatic drive_all(input logic [4:0] r, input logic [4:0] l, input logic rdy);
    for (int d = 0; d < 3; d++) begin
      req_v[d] = r; last_v[d] = l; ready_v[d] = rdy;
    end
  endtask

  initial begin
    nreset = 1'b0;
    drive_all(5'b0, 5'b0, 1'b0);
    step();
    step();
    chk_on = 1'b1;
    chk("reset_grant4", obs_g[1], 5'b00000);
    nreset = 1'b1;

    // Single request
    drive_all(5'b00100, 5'b00100, 1'b1);
    step(); chk("single_grant4", obs_g[1], 5'b00100); chk("single_id4", 5'(obs_id[1]), 5'd2);
    drive_all(5'b00000, 5'b00100, 1'b1);
    step(); chk("single_idle4", obs_g[1], 5'b00000);

    // Full load from reset
    nreset = 1'b0; step(); nreset = 1'b1;
    drive_all(5'b01111, 5'b01111, 1'b1);
    step(); chk("full0_grant4", obs_g[1], 5'b00001);
    step(); chk("full1_grant4", obs_g[1], 5'b00010);
    step(); chk("full2_grant4", obs_g[1], 5'b00100);
    step(); chk("full3_grant4", obs_g[1], 5'b01000);
    step(); chk("full4_grant4", obs_g[1], 5'b00001);
    drive_all(5'b00000, 5'b00000, 1'b1);
    step();

    // Packet lock: req0 three beats, req1 waiting
    nreset = 1'b0; step(); nreset = 1'b1;
    drive_all(5'b00011, 5'b00000, 1'b1);
    step(); chk("lock_b1_grant4", obs_g[1], 5'b00001);
    step(); chk("lock_b2_grant4", obs_g[1], 5'b00001);
    step(); chk("lock_b3_grant4", obs_g[1], 5'b00001);
    drive_all(5'b00011, 5'b00001, 1'b1);
    step(); chk("lock_next_grant4", obs_g[1], 5'b00010);

    // Backpressure on grant 0010 with req0 pending
    drive_all(5'b00011, 5'b00000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(); chk($sformatf("bp%0d_grant4", i), obs_g[1], 5'b00010);
    end
    drive_all(5'b00011, 5'b00011, 1'b1);
    step(); chk("bp_after_grant4", obs_g[1], 5'b00001);
    drive_all(5'b00000, 5'b00000, 1'b1);
    step();

    // Wrap-around
    drive_all(5'b01000, 5'b01000, 1'b1);
    step(); chk("wrap_a_grant4", obs_g[1], 5'b01000);
    drive_all(5'b01001, 5'b01001, 1'b1);
    step(); chk("wrap_b_grant4", obs_g[1], 5'b00001);
    step(); chk("wrap_c_grant4", obs_g[1], 5'b01000);
    drive_all(5'b00000, 5'b00000, 1'b1);
    step();

    // Reset mid-transfer
    drive_all(5'b00100, 5'b00000, 1'b0);
    step(); chk("rst_pre_grant4", obs_g[1], 5'b00100);
    nreset = 1'b0;
    step(); chk("rst_mid_grant4", obs_g[1], 5'b00000); chk("rst_mid_valid4", 5'(obs_v[1]), 5'd0);
    nreset = 1'b1;
    drive_all(5'b11111, 5'b00000, 1'b0);
    step(); chk("rst_post_grant4", obs_g[1], 5'b00001);

    // Random traffic with occasional request drops and resets
    for (int s = 0; s < 400; s++) begin
      nreset = ($urandom_range(199) != 0);
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < NS[d]; i++) begin
          if (req_v[d][i]) begin
            if ($urandom_range(7) == 0) req_v[d][i] = 1'b0;
          end else if ($urandom_range(2) == 0) begin
            req_v[d][i] = 1'b1;
          end
          last_v[d][i] = ($urandom_range(2) == 0);
        end
        ready_v[d] = ($urandom_range(3) != 0);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
